// File: rtl/pattern_match_engine.sv
// Pipelined casez-style pattern classifier: programmable {pat, mask, en} table,
// lowest-index priority hit, multi-hit flag and saturating per-entry hit/miss counters.
module pattern_match_engine #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned MODE  = 1,
    parameter int unsigned CNT_W = 16,
    localparam int unsigned IW   = $clog2(DEPTH),
    localparam int unsigned SW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [IW-1:0]    cfg_idx,
    input  logic [WIDTH-1:0] cfg_pat,
    input  logic [WIDTH-1:0] cfg_mask,
    input  logic             cfg_en,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hit,
    output logic [IW-1:0]    out_idx,
    output logic             out_multi,
    input  logic [SW-1:0]    cnt_sel,
    output logic [CNT_W-1:0] cnt_val,
    input  logic             cnt_clr
);

    logic [WIDTH-1:0] pat  [DEPTH];
    logic [WIDTH-1:0] mask [DEPTH];
    logic [DEPTH-1:0] en;
    logic [CNT_W-1:0] cnt  [DEPTH+1];

    logic [DEPTH-1:0] match;
    logic             hit;
    logic [IW-1:0]    idx;
    logic             multi;
    logic             accept;
    logic [DEPTH:0]   inc;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        match = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (MODE == 0)
                match[i] = en[i] && (in_data == pat[i]);
            else
                match[i] = en[i] && (((in_data ^ pat[i]) & mask[i]) == '0);
        end
    end

    // First match found claims the index; any later match marks a multi-hit.
    always_comb begin
        hit   = 1'b0;
        idx   = '0;
        multi = 1'b0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (match[i]) begin
                if (hit) begin
                    multi = 1'b1;
                end else begin
                    hit = 1'b1;
                    idx = IW'(i);
                end
            end
        end
    end

    always_comb begin
        inc = '0;
        for (int unsigned i = 0; i < DEPTH; i++)
            inc[i] = accept && hit && (idx == IW'(i));
        inc[DEPTH] = accept && !hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                pat[i]  <= '0;
                mask[i] <= '0;
            end
            en <= '0;
        end else if (cfg_we) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                if (cfg_idx == IW'(i)) begin
                    pat[i]  <= cfg_pat;
                    mask[i] <= cfg_mask;
                    en[i]   <= cfg_en;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_hit   <= 1'b0;
            out_idx   <= '0;
            out_multi <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_hit   <= hit;
            out_idx   <= idx;
            out_multi <= multi;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i <= DEPTH; i++)
                cnt[i] <= '0;
        end else begin
            for (int unsigned i = 0; i <= DEPTH; i++) begin
                if (cnt_clr)
                    cnt[i] <= '0;
                else if (inc[i] && (cnt[i] != '1))
                    cnt[i] <= cnt[i] + 1'b1;
            end
        end
    end

    // Selects above DEPTH fall through to zero.
    always_comb begin
        cnt_val = '0;
        for (int unsigned i = 0; i <= DEPTH; i++) begin
            if (cnt_sel == SW'(i))
                cnt_val = cnt[i];
        end
    end

endmodule
